md_sequencer: RTL
=================

# md_sequencer

Multi-cycle multiply/divide sequencer for the CPU execute stage. It accepts one MULT/MULTU/DIV/DIVU request at a time and iterates a single 33-bit add/subtract datapath over 32 cycles. It owns the HI/LO registers, supports MTHI/MTLO writes, and drives a busy flag that the stall unit uses to hold later HI/LO-dependent instructions.

## Interface
Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only when busy=0.
- md_op  in  2  0 MULT (signed), 1 MULTU, 2 DIV (signed), 3 DIVU.
- a  in  WIDTH  multiplicand or dividend (rs).
- b  in  WIDTH  multiplier or divisor (rt).
- mt_we  in  1  MTHI/MTLO write enable.
- mt_sel  in  1  0 writes LO, 1 writes HI.
- mt_data  in  WIDTH  write data.
- busy  out  1  operation in progress.
- hi  out  WIDTH  HI register (product high half or remainder).
- lo  out  WIDTH  LO register (product low half or quotient).

## Operation
- FSM states: IDLE, PREP, ITER, FIX.
- IDLE:
  - start=1: latch md_op; form |a| and |b| (signed ops) or raw a and b (unsigned ops); record sign flags; go to PREP.
  - mt_we=1 and start=0: write mt_data into HI or LO.
  - start and mt_we both high: start wins; the write is dropped.
- PREP:
  - Multiply: lo ← multiplier, hi ← 0, carry ← 0.
  - Divide: lo ← dividend, hi ← 0.
  - Clear the 5-bit counter.
- ITER runs 32 cycles; the counter wraps 31→0 on the exit cycle.
  - Multiply step: sum[32:0] = {1'b0,hi} + (lo[0] ? mcand : 0); then {hi,lo} ← {sum,lo} >> 1, taking the full 33-bit sum and dropping lo[0].
  - Divide step: r[32:0] = {hi,lo[31]}; t = r − {1'b0,divisor}. If t[32]=0: hi ← t[31:0], q bit = 1. Otherwise hi ← r[31:0], q bit = 0. Then lo ← {lo[30:0], q bit}.
- FIX (1 cycle), then go to IDLE:
  - Signed multiply with operand signs different: {hi,lo} ← −{hi,lo} as a 64-bit two's complement.
  - Signed divide: negate lo if operand signs differ; negate hi if the dividend is negative.
  - Divide by zero, any divide op: skip all correction and force hi ← original a, lo ← 32'hFFFFFFFF.
  - 0x80000000 / −1 (signed): lo = 0x80000000, hi = 0. No trap.
- While busy=1, start and mt_we are ignored and do not queue.

## Timing
- Reset (asynchronous, immediate): state = IDLE, busy = 0, hi = 0, lo = 0, counter = 0.
- Accepting edge E0 puts state = PREP. busy goes high after E0 and stays high for exactly 34 cycles (PREP + 32 ITER + FIX).
- Final hi/lo are written on the FIX edge, which is the same edge where busy falls. They are readable the cycle busy=0.
- A new start is accepted in the first cycle with busy=0, so back-to-back operations are 35 cycles apart.
- An MTHI/MTLO write lands on the next edge and is visible the following cycle.
- Intermediate hi/lo values during ITER are architecturally undefined; consumers must stall on busy.
- reset_n asserted mid-ITER aborts the operation: all state clears at once and no partial result is retained.

## Structure
- Package md_pkg:
  - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU encodings.
  - FSM state enum.
  - ITER_COUNT = 32.
- Sub-module md_addsub: 33-bit adder/subtractor (sub input, a/b inputs, 33-bit result). Instantiated once and shared by multiply add and divide trial-subtract.
- Sign pre-negation and FIX negation live in the top-level.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 34 cycles.
- MULT a=−3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=7, b=0 → hi=7, lo=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- start pulse and mt_we during busy are ignored, and the result is unchanged. With start=mt_we=1 in IDLE, the operation runs and the MT write is dropped. MTHI 0x1234 while idle → hi=0x1234 next cycle.
- reset_n low at ITER cycle 10 → busy=0, hi=lo=0 immediately. A subsequent MULTU 6×7 → lo=42, hi=0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings and constants for the multiply/divide sequencer.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    typedef logic [1:0] md_state_t;
    localparam md_state_t ST_IDLE = 2'd0;
    localparam md_state_t ST_PREP = 2'd1;
    localparam md_state_t ST_ITER = 2'd2;
    localparam md_state_t ST_FIX  = 2'd3;

    localparam int ITER_COUNT = 32;

endpackage

// File: rtl/md_addsub.sv
// Shared adder/subtractor used by both the multiply add and the divide trial-subtract.
module md_addsub #(
    parameter int W = 33
) (
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result
);

    logic [W-1:0] b_eff;

    assign b_eff  = sub ? ~b : b;
    assign result = a + b_eff + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/md_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one add/subtract per cycle,
// with operand magnitudes formed on accept and sign correction in a final FIX cycle.
module md_sequencer
    import md_pkg::*;
#(
    parameter int WIDTH = ITER_COUNT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mt_we,
    input  logic             mt_sel,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    md_state_t        state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] a_orig_q, a_orig_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   as_a, as_b, as_sum;
    logic             as_sub;
    logic             sign_a, sign_b;
    logic             is_div;

    assign is_div = op_q[1];
    assign busy   = (state_q != ST_IDLE);
    assign hi     = hi_q;
    assign lo     = lo_q;

    // Multiply: opa is the multiplicand. Divide: opb is the divisor, trial-subtracted from {hi, lo msb}.
    always_comb begin
        if (is_div) begin
            as_a   = {hi_q, lo_q[WIDTH-1]};
            as_b   = {1'b0, opb_q};
            as_sub = 1'b1;
        end else begin
            as_a   = {1'b0, hi_q};
            as_b   = lo_q[0] ? {1'b0, opa_q} : '0;
            as_sub = 1'b0;
        end
    end

    md_addsub #(.W(WIDTH + 1)) u_addsub (
        .sub    (as_sub),
        .a      (as_a),
        .b      (as_b),
        .result (as_sum)
    );

    assign sign_a = ~md_op[0] & a[WIDTH-1];
    assign sign_b = ~md_op[0] & b[WIDTH-1];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        a_orig_d = a_orig_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = md_op;
                    opa_d    = sign_a ? -a : a;
                    opb_d    = sign_b ? -b : b;
                    a_orig_d = a;
                    neg_q_d  = sign_a ^ sign_b;
                    neg_r_d  = sign_a;
                    state_d  = ST_PREP;
                end else if (mt_we) begin
                    if (mt_sel) begin
                        hi_d = mt_data;
                    end else begin
                        lo_d = mt_data;
                    end
                end
            end
            ST_PREP: begin
                hi_d    = '0;
                lo_d    = is_div ? opa_q : opb_q;
                cnt_d   = '0;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                if (is_div) begin
                    hi_d = as_sum[WIDTH] ? as_a[WIDTH-1:0] : as_sum[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], ~as_sum[WIDTH]};
                end else begin
                    hi_d = as_sum[WIDTH:1];
                    lo_d = {as_sum[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // Unsigned ops never set the negate flags, so no op check is needed here.
                if (is_div) begin
                    if (opb_q == '0) begin
                        hi_d = a_orig_q;
                        lo_d = '1;
                    end else begin
                        if (neg_q_q) lo_d = -lo_q;
                        if (neg_r_q) hi_d = -hi_q;
                    end
                end else if (neg_q_q) begin
                    {hi_d, lo_d} = -{hi_q, lo_q};
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            a_orig_q <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            a_orig_q <= a_orig_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
